uart_bus_bridge: RTL and testbench

//  UART-to-register-bus initiator. Decodes command frames from a host on rx_i,

---
 rtl/uart_bus_bridge.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge.sv
// UART command-frame decoder that issues single-cycle register bus accesses.
// Frame: {wr,3'b000,addr} [+4 data bytes LSB first]; reply ACK 0xAA, 4 read bytes, or NAK 0x55.
module uart_bus_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        ren,
  output logic        we,
  output logic [3:0]  addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy_o,
  output logic        err_o
);
  localparam int CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ZERO   = {TO_W{1'b0}};
  localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
  localparam logic [7:0] ACK_BYTE = 8'hAA;
  localparam logic [7:0] NAK_BYTE = 8'h55;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, GET_DATA, BUS_WR, BUS_RD, SEND, NAK} state_t;

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             r_rx_valid;
  logic             r_rx_ferr;
  logic [7:0]       r_rx_byte;

  state_t           r_state;
  logic [TO_W-1:0]  r_to_cnt;
  logic [2:0]       r_byte_cnt;
  logic [23:0]      r_wbuf;
  logic [3:0]       r_addr_pend;
  logic [31:0]      r_tx_buf;
  logic [2:0]       r_tx_left;
  logic [8:0]       r_tx_shift;
  logic [3:0]       r_tx_bit;
  logic [CNT_W-1:0] r_tx_cnt;

  logic w_rx_start;
  logic w_drop;

  assign w_rx_start = (r_rx_state == RX_IDLE) && r_rx_prev && !r_rx_sync;
  assign w_drop     = r_rx_valid && (r_state != IDLE) && (r_state != GET_DATA);

  // Receiver: synchroniser, start-bit qualification and mid-bit sampling.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= CNT_ZERO;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_byte  <= 8'h00;
    end else begin
      r_rx_meta  <= rx_i;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= CNT_ZERO;
          if (w_rx_start) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt   <= CNT_ZERO;
            r_rx_bit   <= 3'd0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= CNT_ZERO;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt   <= CNT_ZERO;
            r_rx_state <= RX_IDLE;
            if (r_rx_sync) begin
              r_rx_valid <= 1'b1;
              r_rx_byte  <= r_rx_shift;
            end else begin
              r_rx_ferr <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_ONE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Frame decoder, bus strobes and transmitter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      tx_o        <= 1'b1;
      ren         <= 1'b0;
      we          <= 1'b0;
      addr        <= 4'h0;
      wdata       <= 32'h0000_0000;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
      r_to_cnt    <= TO_ZERO;
      r_byte_cnt  <= 3'd0;
      r_wbuf      <= 24'h00_0000;
      r_addr_pend <= 4'h0;
      r_tx_buf    <= 32'h0000_0000;
      r_tx_left   <= 3'd0;
      r_tx_shift  <= 9'h1FF;
      r_tx_bit    <= 4'd0;
      r_tx_cnt    <= CNT_ZERO;
    end else begin
      ren   <= 1'b0;
      we    <= 1'b0;
      err_o <= r_rx_ferr | w_drop;
      case (r_state)
        IDLE: begin
          if (r_rx_valid) begin
            busy_o <= 1'b1;
            if (r_rx_byte[6:4] != 3'b000) begin
              err_o      <= 1'b1;
              r_state    <= NAK;
              tx_o       <= 1'b0;
              r_tx_shift <= {1'b1, NAK_BYTE};
              r_tx_bit   <= 4'd0;
              r_tx_cnt   <= CNT_ZERO;
              r_tx_left  <= 3'd0;
            end else begin
              r_addr_pend <= r_rx_byte[3:0];
              r_byte_cnt  <= 3'd0;
              r_to_cnt    <= TO_ZERO;
              r_state     <= r_rx_byte[7] ? GET_DATA : BUS_RD;
            end
          end
        end
        GET_DATA: begin
          if (r_rx_ferr) begin
            r_state <= IDLE;
            busy_o  <= 1'b0;
          end else if (r_rx_valid) begin
            r_to_cnt   <= TO_ZERO;
            r_byte_cnt <= r_byte_cnt + 3'd1;
            case (r_byte_cnt)
              3'd0: r_wbuf[7:0]   <= r_rx_byte;
              3'd1: r_wbuf[15:8]  <= r_rx_byte;
              3'd2: r_wbuf[23:16] <= r_rx_byte;
              default: begin
                wdata   <= {r_rx_byte, r_wbuf};
                addr    <= r_addr_pend;
                r_state <= BUS_WR;
              end
            endcase
          end else if (w_rx_start) begin
            r_to_cnt <= TO_ZERO;
          end else if (r_rx_state == RX_IDLE) begin
            // Inter-byte silence only; time spent inside a byte never counts.
            if (r_to_cnt == TO_LAST) begin
              err_o   <= 1'b1;
              r_state <= IDLE;
              busy_o  <= 1'b0;
            end else begin
              r_to_cnt <= r_to_cnt + TO_ONE;
            end
          end else begin
            r_to_cnt <= r_to_cnt;
          end
        end
        BUS_WR: begin
          if (!we) begin
            we <= 1'b1;
          end else begin
            r_state    <= SEND;
            tx_o       <= 1'b0;
            r_tx_shift <= {1'b1, ACK_BYTE};
            r_tx_bit   <= 4'd0;
            r_tx_cnt   <= CNT_ZERO;
            r_tx_left  <= 3'd0;
          end
        end
        BUS_RD: begin
          if (!ren) begin
            ren  <= 1'b1;
            addr <= r_addr_pend;
          end else begin
            r_state    <= SEND;
            tx_o       <= 1'b0;
            r_tx_shift <= {1'b1, rdata[7:0]};
            r_tx_buf   <= {8'h00, rdata[31:8]};
            r_tx_bit   <= 4'd0;
            r_tx_cnt   <= CNT_ZERO;
            r_tx_left  <= 3'd3;
          end
        end
        SEND, NAK: begin
          if (r_tx_cnt != BIT_LAST) begin
            r_tx_cnt <= r_tx_cnt + CNT_ONE;
          end else begin
            r_tx_cnt <= CNT_ZERO;
            // r_tx_bit==9 marks the end of the stop bit of the current byte.
            if (r_tx_bit != 4'd9) begin
              tx_o       <= r_tx_shift[0];
              r_tx_shift <= {1'b1, r_tx_shift[8:1]};
              r_tx_bit   <= r_tx_bit + 4'd1;
            end else if (r_tx_left != 3'd0) begin
              tx_o       <= 1'b0;
              r_tx_shift <= {1'b1, r_tx_buf[7:0]};
              r_tx_buf   <= {8'h00, r_tx_buf[31:8]};
              r_tx_left  <= r_tx_left - 3'd1;
              r_tx_bit   <= 4'd0;
            end else begin
              r_state <= IDLE;
              busy_o  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          busy_o  <= 1'b0;
          tx_o    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed plus randomized frames against a frame-level model of the bridge.
module tb_uart_bus_bridge;
  localparam int CPB = 8;
  localparam int TOB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        tx_o;
  logic        ren;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] rd_val;
  logic        busy_o;
  logic        err_o;

  always #5 clk = ~clk;

  // Responder drives valid data only while ren is high.
  assign rdata = ren ? rd_val : 32'hDEAD_BEEF;

  uart_bus_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .tx_o(tx_o), .ren(ren), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy_o(busy_o), .err_o(err_o)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int we_cnt = 0, ren_cnt = 0, both_cnt = 0, err_cnt = 0, tx_follow = 0, busy_bad = 0;
  int tx_stop_bad = 0;
  logic       strobe_prev = 1'b0;
  logic [7:0] tx_q[$];

  int base_we, base_ren, base_both, base_err, base_follow, base_busy, base_stop, base_tx;
  logic [7:0]  exp_q[$];
  logic [3:0]  m_addr;
  logic [31:0] m_wdata;

  // Bus strobe / error observer.
  always @(negedge clk) begin
    if (we === 1'b1) we_cnt++;
    if (ren === 1'b1) ren_cnt++;
    if (we === 1'b1 && ren === 1'b1) both_cnt++;
    if (err_o === 1'b1) err_cnt++;
    if ((we === 1'b1 || ren === 1'b1) && busy_o !== 1'b1) busy_bad++;
    if (strobe_prev && tx_o === 1'b0) tx_follow++;
    strobe_prev = (we === 1'b1) || (ren === 1'b1);
  end

  // Serial receiver for tx_o.
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_o === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx_o;
        end
        repeat (CPB) @(negedge clk);
        if (tx_o !== 1'b1) tx_stop_bad++;
        tx_q.push_back(b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic begin_frame();
    base_we = we_cnt; base_ren = ren_cnt; base_both = both_cnt; base_err = err_cnt;
    base_follow = tx_follow; base_busy = busy_bad; base_stop = tx_stop_bad;
    base_tx = tx_q.size();
    exp_q.delete();
  endtask

  task automatic end_frame(input string tag, input int ew, input int er, input int ee);
    int idx;
    repeat (450) @(negedge clk);
    check({tag, "/we_pulses"}, 32'(we_cnt - base_we), 32'(ew));
    check({tag, "/ren_pulses"}, 32'(ren_cnt - base_ren), 32'(er));
    check({tag, "/err_pulses"}, 32'(err_cnt - base_err), 32'(ee));
    check({tag, "/we_and_ren"}, 32'(both_cnt - base_both), 32'd0);
    check({tag, "/tx_after_strobe"}, 32'(tx_follow - base_follow), 32'(ew + er));
    check({tag, "/busy_at_strobe"}, 32'(busy_bad - base_busy), 32'd0);
    check({tag, "/tx_count"}, 32'(tx_q.size() - base_tx), 32'(exp_q.size()));
    check({tag, "/tx_stop"}, 32'(tx_stop_bad - base_stop), 32'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      idx = base_tx + i;
      check({tag, "/tx_byte"}, (idx < tx_q.size()) ? {24'h0, tx_q[idx]} : 32'h100,
            {24'h0, exp_q[i]});
    end
    check({tag, "/addr"}, {28'h0, addr}, {28'h0, m_addr});
    check({tag, "/wdata"}, wdata, m_wdata);
    check({tag, "/busy_idle"}, 32'(busy_o), 32'd0);
    check({tag, "/tx_idle"}, 32'(tx_o), 32'd1);
  endtask

  // Frame-level model: decides the outcome purely from the command byte.
  task automatic do_frame(input string tag, input logic [7:0] cmd, input logic [31:0] data,
                          input logic [31:0] rv);
    int ew, er, ee;
    begin_frame();
    ew = 0; er = 0; ee = 0;
    rd_val = rv;
    send_byte(cmd, 1'b1);
    if (cmd[6:4] != 3'b000) begin
      ee = 1;
      exp_q.push_back(8'h55);
    end else if (cmd[7]) begin
      for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], 1'b1);
      ew = 1;
      m_addr  = cmd[3:0];
      m_wdata = data;
      exp_q.push_back(8'hAA);
    end else begin
      er = 1;
      m_addr = cmd[3:0];
      for (int i = 0; i < 4; i++) exp_q.push_back(rv[8*i +: 8]);
    end
    end_frame(tag, ew, er, ee);
  endtask

  initial begin : main
    int k;
    int kind;
    logic [7:0] c;
    rst = 1'b1;
    rx = 1'b1;
    rd_val = 32'h0000_0000;
    m_addr = 4'h0;
    m_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset/tx_o", 32'(tx_o), 32'd1);
    check("reset/ren", 32'(ren), 32'd0);
    check("reset/we", 32'(we), 32'd0);
    check("reset/addr", {28'h0, addr}, 32'd0);
    check("reset/wdata", wdata, 32'd0);
    check("reset/busy", 32'(busy_o), 32'd0);
    check("reset/err", 32'(err_o), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    do_frame("write", 8'h84, 32'h1234_5678, 32'h0);
    do_frame("read", 8'h08, 32'h0, 32'hCAFE_0042);

    begin_frame();
    send_byte(8'h84, 1'b0);
    end_frame("framing", 0, 0, 1);

    do_frame("bad_cmd", 8'h10, 32'h0, 32'h0);

    begin_frame();
    send_byte(8'h80, 1'b1);
    send_byte(8'h11, 1'b1);
    end_frame("timeout", 0, 0, 1);

    for (int f = 0; f < 10; f++) begin
      kind = $urandom_range(2, 0);
      case (kind)
        0: c = {1'b1, 3'b000, 4'($urandom)};
        1: c = {1'b0, 3'b000, 4'($urandom)};
        default: c = {1'($urandom), 3'($urandom_range(7, 1)), 4'($urandom)};
      endcase
      do_frame("random", c, $urandom(), $urandom());
    end

    rd_val = 32'h8181_8181;
    send_byte(8'h03, 1'b1);
    k = 0;
    while (tx_o !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid/tx_started", 32'(k < 300), 32'd1);
    repeat (3) @(negedge clk);
    check("rst_mid/tx_low", 32'(tx_o), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid/tx_o", 32'(tx_o), 32'd1);
    check("rst_mid/busy", 32'(busy_o), 32'd0);
    check("rst_mid/addr", {28'h0, addr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_addr = 4'h0;
    m_wdata = 32'h0;
    repeat (120) @(negedge clk);
    do_frame("post_rst_read", 8'h0B, 32'h0, 32'h1357_9BDF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
